// File: rtl/reaction_fsm.sv
// Reaction-time engine: random pre-stimulus delay, then a 4-digit BCD millisecond
// count until stop, with early-start and timeout detection.
module reaction_fsm #(
  parameter int          MIN_DELAY_MS = 2000,
  parameter logic [11:0] RAND_MASK    = 12'hFFF,
  parameter int          MAX_MS       = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic       led,
  output logic [3:0] bcd3,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic       done,
  output logic       early,
  output logic       timeout
);

  // state   | meaning
  // IDLE    | no measurement, all outputs cleared
  // WAIT    | counting down the pre-stimulus delay
  // ARMED   | LED lit, counting elapsed ms
  // DONE    | valid reaction time held
  // EARLY   | stop seen before the stimulus
  // TIMEOUT | no stop before MAX_MS
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_ARMED   = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_EARLY   = 3'd4;
  localparam logic [2:0] S_TIMEOUT = 3'd5;

  localparam logic [15:0] MAX_BCD = {4'(MAX_MS / 1000), 4'((MAX_MS / 100) % 10),
                                     4'((MAX_MS / 10) % 10), 4'(MAX_MS % 10)};
  localparam logic [13:0] MIN_D   = 14'(MIN_DELAY_MS);

  logic [2:0]  state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [13:0] delay_q, delay_d;
  logic [15:0] bcd_q, bcd_d;
  logic        start_s_q, start_s_d, start_p_q, start_p_d;
  logic        stop_s_q, stop_s_d, stop_p_q, stop_p_d;
  logic        led_q, led_d, done_q, done_d, early_q, early_d, timeout_q, timeout_d;

  logic        start_edge, stop_edge;
  logic [13:0] delay_load;
  logic [15:0] bcd_next;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Inputs are sampled once, then compared with the previous sample.
  assign start_edge = start_s_q & ~start_p_q;
  assign stop_edge  = stop_s_q & ~stop_p_q;
  assign delay_load = MIN_D + {2'b00, lfsr_q[11:0] & RAND_MASK};
  assign bcd_next   = bcd_inc(bcd_q);

  always_comb begin
    start_s_d = start;
    start_p_d = start_s_q;
    stop_s_d  = stop;
    stop_p_d  = stop_s_q;
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    state_d   = state_q;
    delay_d   = delay_q;
    bcd_d     = bcd_q;

    if (clear) begin
      state_d = S_IDLE;
      bcd_d   = 16'h0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            state_d = S_WAIT;
            delay_d = delay_load;
          end
        end
        S_WAIT: begin
          if (stop_edge) begin
            state_d = S_EARLY;
            bcd_d   = 16'h0000;
          end else if (tick) begin
            // A zero delay arms on the first tick, same as a delay of one.
            if (delay_q <= 14'd1) begin
              state_d = S_ARMED;
              bcd_d   = 16'h0000;
            end else begin
              delay_d = delay_q - 14'd1;
            end
          end
        end
        S_ARMED: begin
          if (stop_edge) begin
            state_d = S_DONE;
          end else if (tick) begin
            if (bcd_next >= MAX_BCD) begin
              state_d = S_TIMEOUT;
              bcd_d   = MAX_BCD;
            end else begin
              bcd_d = bcd_next;
            end
          end
        end
        S_DONE, S_EARLY, S_TIMEOUT: begin
          if (start_edge) begin
            state_d = S_WAIT;
            delay_d = delay_load;
          end
        end
        default: begin
          state_d = S_IDLE;
          bcd_d   = 16'h0000;
        end
      endcase
    end

    led_d     = (state_d == S_ARMED);
    done_d    = (state_d == S_DONE);
    early_d   = (state_d == S_EARLY);
    timeout_d = (state_d == S_TIMEOUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_SEED;
      delay_q   <= 14'd0;
      bcd_q     <= 16'h0000;
      start_s_q <= 1'b0;
      start_p_q <= 1'b0;
      stop_s_q  <= 1'b0;
      stop_p_q  <= 1'b0;
      led_q     <= 1'b0;
      done_q    <= 1'b0;
      early_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      delay_q   <= delay_d;
      bcd_q     <= bcd_d;
      start_s_q <= start_s_d;
      start_p_q <= start_p_d;
      stop_s_q  <= stop_s_d;
      stop_p_q  <= stop_p_d;
      led_q     <= led_d;
      done_q    <= done_d;
      early_q   <= early_d;
      timeout_q <= timeout_d;
    end
  end

  assign led     = led_q;
  assign done    = done_q;
  assign early   = early_q;
  assign timeout = timeout_q;
  assign bcd3    = bcd_q[15:12];
  assign bcd2    = bcd_q[11:8];
  assign bcd1    = bcd_q[7:4];
  assign bcd0    = bcd_q[3:0];

endmodule

// File: tb/tb_reaction_fsm.sv
// Directed bench for reaction_fsm: a per-cycle vector table plus long multi-tick
// sequences (counting, timeout, carry ripple, simultaneous events, async reset).
module tb_reaction_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;

  logic       led_a, done_a, early_a, tout_a;
  logic [3:0] b3_a, b2_a, b1_a, b0_a;
  logic       led_b, done_b, early_b, tout_b;
  logic [3:0] b3_b, b2_b, b1_b, b0_b;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  reaction_fsm #(.MIN_DELAY_MS(3), .RAND_MASK(12'h000), .MAX_MS(9999), .LFSR_SEED(16'hACE1)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .clear(clear),
    .led(led_a), .bcd3(b3_a), .bcd2(b2_a), .bcd1(b1_a), .bcd0(b0_a),
    .done(done_a), .early(early_a), .timeout(tout_a));

  reaction_fsm #(.MIN_DELAY_MS(3), .RAND_MASK(12'h000), .MAX_MS(12), .LFSR_SEED(16'hACE1)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .clear(clear),
    .led(led_b), .bcd3(b3_b), .bcd2(b2_b), .bcd1(b1_b), .bcd0(b0_b),
    .done(done_b), .early(early_b), .timeout(tout_b));

  typedef struct {
    logic [4:0]  in;   // {rst, start, stop, clear, tick}
    logic [3:0]  fl;   // {led, done, early, timeout}
    logic [15:0] bcd;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(input logic [4:0] in, input logic [3:0] fl, input logic [15:0] bcd);
    vec_t v;
    v.in  = in;
    v.fl  = fl;
    v.bcd = bcd;
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [31:0] pk(input logic [3:0] fl, input logic [15:0] bcd);
    return {12'h000, fl, bcd};
  endfunction

  function automatic logic [31:0] got_a();
    return {12'h000, led_a, done_a, early_a, tout_a, b3_a, b2_a, b1_a, b0_a};
  endfunction

  function automatic logic [31:0] got_b();
    return {12'h000, led_b, done_b, early_b, tout_b, b3_b, b2_b, b1_b, b0_b};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic p, input logic c, input logic t);
    @(negedge clk);
    start = s;
    stop  = p;
    clear = c;
    tick  = t;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (9) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Start a measurement and count ticks until the LED lights (bounded).
  task automatic go_armed(output int nt);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    nt = 0;
    while (led_a !== 1'b1 && nt < 20) begin
      tick_pulse();
      nt++;
    end
  endtask

  task automatic stop_press(input logic with_tick, input logic with_clear);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, with_clear, with_tick);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int nt;

    vecs[0]  = mk(5'b10000, 4'b0000, 16'h0000);
    vecs[1]  = mk(5'b01000, 4'b0000, 16'h0000);
    vecs[2]  = mk(5'b01000, 4'b0000, 16'h0000);
    vecs[3]  = mk(5'b00001, 4'b0000, 16'h0000);
    vecs[4]  = mk(5'b00100, 4'b0000, 16'h0000);
    vecs[5]  = mk(5'b00101, 4'b0010, 16'h0000);
    vecs[6]  = mk(5'b00001, 4'b0010, 16'h0000);
    vecs[7]  = mk(5'b00000, 4'b0010, 16'h0000);
    vecs[8]  = mk(5'b00010, 4'b0000, 16'h0000);
    vecs[9]  = mk(5'b00000, 4'b0000, 16'h0000);
    vecs[10] = mk(5'b01000, 4'b0000, 16'h0000);
    vecs[11] = mk(5'b01000, 4'b0000, 16'h0000);
    vecs[12] = mk(5'b00001, 4'b0000, 16'h0000);
    vecs[13] = mk(5'b00001, 4'b0000, 16'h0000);
    vecs[14] = mk(5'b00000, 4'b0000, 16'h0000);
    vecs[15] = mk(5'b00001, 4'b1000, 16'h0000);
    vecs[16] = mk(5'b00001, 4'b1000, 16'h0001);
    vecs[17] = mk(5'b00001, 4'b1000, 16'h0002);
    vecs[18] = mk(5'b01000, 4'b1000, 16'h0002);
    vecs[19] = mk(5'b01000, 4'b1000, 16'h0002);
    vecs[20] = mk(5'b00100, 4'b1000, 16'h0002);
    vecs[21] = mk(5'b00100, 4'b0100, 16'h0002);
    vecs[22] = mk(5'b00001, 4'b0100, 16'h0002);
    vecs[23] = mk(5'b01000, 4'b0100, 16'h0002);
    vecs[24] = mk(5'b01000, 4'b0000, 16'h0002);
    vecs[25] = mk(5'b00001, 4'b0000, 16'h0002);
    vecs[26] = mk(5'b00010, 4'b0000, 16'h0000);

    repeat (2) @(posedge clk);
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      {rst, start, stop, clear, tick} = vecs[i].in;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), got_a(), pk(vecs[i].fl, vecs[i].bcd));
    end

    // 247 ms reaction; the MAX_MS=12 instance times out along the way.
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    go_armed(nt);
    chk("arm_ticks_247", 32'(nt), 32'd3);
    for (int i = 1; i <= 247; i++) begin
      tick_pulse();
      if (i == 11) chk("b_before_timeout", got_b(), pk(4'b1000, to_bcd(11)));
      if (i == 12) chk("b_timeout", got_b(), pk(4'b0001, to_bcd(12)));
    end
    chk("count_247", got_a(), pk(4'b1000, to_bcd(247)));
    stop_press(1'b0, 1'b0);
    chk("done_247", got_a(), pk(4'b0100, to_bcd(247)));
    chk("b_timeout_held", got_b(), pk(4'b0001, to_bcd(12)));

    // Stop edge and tick together at 0099: tick not counted.
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    go_armed(nt);
    repeat (99) tick_pulse();
    stop_press(1'b1, 1'b0);
    chk("stop_tick_0099", got_a(), pk(4'b0100, to_bcd(99)));

    // Clear together with a stop edge in ARMED.
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    go_armed(nt);
    repeat (5) tick_pulse();
    stop_press(1'b0, 1'b1);
    chk("clear_vs_stop", got_a(), pk(4'b0000, 16'h0000));

    // Carry ripple 0999 -> 1000, then restart from DONE.
    go_armed(nt);
    repeat (999) tick_pulse();
    chk("count_0999", got_a(), pk(4'b1000, to_bcd(999)));
    tick_pulse();
    chk("count_1000", got_a(), pk(4'b1000, to_bcd(1000)));
    stop_press(1'b0, 1'b0);
    chk("done_1000", got_a(), pk(4'b0100, to_bcd(1000)));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_wait", got_a(), pk(4'b0000, to_bcd(1000)));
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tick_pulse();
    tick_pulse();
    chk("restart_2_ticks", got_a(), pk(4'b0000, to_bcd(1000)));
    tick_pulse();
    chk("restart_armed", got_a(), pk(4'b1000, 16'h0000));

    // Async reset mid-ARMED, then mid-WAIT.
    repeat (5) tick_pulse();
    #2 rst = 1'b1;
    #1 chk("rst_armed_now", got_a(), pk(4'b0000, 16'h0000));
    @(negedge clk) rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_armed_after", got_a(), pk(4'b0000, 16'h0000));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tick_pulse();
    #2 rst = 1'b1;
    #1 chk("rst_wait_now", got_a(), pk(4'b0000, 16'h0000));
    @(negedge clk) rst = 1'b0;
    go_armed(nt);
    chk("rst_wait_rearm", 32'(nt), 32'd3);
    chk("rst_wait_armed", got_a(), pk(4'b1000, 16'h0000));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
